k054539_dac_rx: RTL and testbench

Serial audio receiver on the 054539's DAC output: deserializes the bit-clocked, word-clocked PCM stream (DTCK/WDCK/SDAT) into parallel stereo sample pairs in the CLK domain. It is the stage directly downstream of the k054539 core and feeds the mixer and capture logic, including the testbench sample dumper. All serial inputs are oversampled by CLK; no second clock domain exists.

---
 rtl/k054539_pkg.sv | 13 +
 rtl/k054539_dacrx_fifo.sv | 43 ++++
 rtl/k054539_dac_rx.sv | 172 +++++++++++++++++
 tb/tb_k054539_dac_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/k054539_pkg.sv
// Shared types and constants for the k054539 DAC serial receiver.
package k054539_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dacrx_state_t;

  localparam int DACRX_SYNC_STAGES = 2;
  localparam int DACRX_DEF_WIDTH   = 16;

endpackage

// File: rtl/k054539_dacrx_fifo.sv
// Synchronous pair FIFO; full/empty come from a wrap bit carried above the pointer index.
module k054539_dacrx_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO still takes a push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // NOTE: storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/k054539_dac_rx.sv
// Oversampling receiver for the 054539 DTCK/WDCK/SDAT stream into stereo pairs.
// Optional output FIFO enabled by defining K054539_DACRX_FIFO_EN.
module k054539_dac_rx
  import k054539_pkg::*;
#(
  parameter int WIDTH      = DACRX_DEF_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             NRES,
  input  logic             DTCK,
  input  logic             WDCK,
  input  logic             SDAT,
  input  logic             CLR,
  output logic [WIDTH-1:0] OUT_L,
  output logic [WIDTH-1:0] OUT_R,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             SHORT_ERR,
  output logic             OVF
);
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  logic [DACRX_SYNC_STAGES-1:0] dtck_sync_q, wdck_sync_q, sdat_sync_q;
  logic                         dtck_prev_q, wdck_prev_q;
  logic                         dtck_rise, wdck_rise, wdck_fall;

  dacrx_state_t     state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, left_q, left_d, right_q, right_d, word;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             emit_q, emit_d, short_q, short_set, short_word;

  assign dtck_rise = dtck_sync_q[DACRX_SYNC_STAGES-1] && !dtck_prev_q;
  assign wdck_rise = wdck_sync_q[DACRX_SYNC_STAGES-1] && !wdck_prev_q;
  assign wdck_fall = !wdck_sync_q[DACRX_SYNC_STAGES-1] && wdck_prev_q;

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      dtck_sync_q <= '0;
      wdck_sync_q <= '0;
      sdat_sync_q <= '0;
      dtck_prev_q <= 1'b0;
      wdck_prev_q <= 1'b0;
    end else begin
      dtck_sync_q <= {dtck_sync_q[DACRX_SYNC_STAGES-2:0], DTCK};
      wdck_sync_q <= {wdck_sync_q[DACRX_SYNC_STAGES-2:0], WDCK};
      sdat_sync_q <= {sdat_sync_q[DACRX_SYNC_STAGES-2:0], SDAT};
      dtck_prev_q <= dtck_sync_q[DACRX_SYNC_STAGES-1];
      wdck_prev_q <= wdck_sync_q[DACRX_SYNC_STAGES-1];
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    right_d    = right_q;
    emit_d     = 1'b0;
    short_set  = 1'b0;
    // Short words come out left-justified, zero-padded in the LSBs.
    word       = sh_q << (FULL_CNT - cnt_q);
    short_word = (cnt_q != FULL_CNT);

    unique case (state_q)
      SYNC:  if (wdck_rise) state_d = LEFT;
      LEFT:  if (wdck_fall) begin
               left_d    = word;
               short_set = short_word;
               state_d   = RIGHT;
             end
      RIGHT: if (wdck_rise) begin
               right_d   = word;
               short_set = short_word;
               emit_d    = 1'b1;
               state_d   = LEFT;
             end
      default: state_d = SYNC;
    endcase

    // Word end is applied before the bit so a coincident bit opens the new word.
    if (wdck_rise || wdck_fall) begin
      sh_d  = '0;
      cnt_d = '0;
    end
    if (dtck_rise && (cnt_d != FULL_CNT)) begin
      sh_d  = {sh_d[WIDTH-2:0], sdat_sync_q[DACRX_SYNC_STAGES-1]};
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      state_q <= SYNC;
      sh_q    <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      emit_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
      emit_q  <= emit_d;
      short_q <= short_set || (short_q && !CLR);
    end
  end

  assign SHORT_ERR = short_q;

`ifdef K054539_DACRX_FIFO_EN
  logic [2*WIDTH-1:0] head;
  logic               fifo_full, fifo_empty, pop, ovf_q;

  assign pop = !fifo_empty && OUT_READY;

  k054539_dacrx_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (NRES),
    .push_i  (emit_q),
    .data_i  ({left_q, right_q}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) ovf_q <= 1'b0;
    else       ovf_q <= (emit_q && fifo_full && !pop) || (ovf_q && !CLR);
  end

  assign {OUT_L, OUT_R} = fifo_empty ? '0 : head;
  assign OUT_VALID      = !fifo_empty;
  assign OVF            = ovf_q;
`else
  logic [WIDTH-1:0] out_l_q, out_r_q;
  logic             valid_q;
  logic             unused_ready;
  localparam int    fifo_depth_unused = FIFO_DEPTH;

  assign unused_ready = OUT_READY;

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      out_l_q <= '0;
      out_r_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= emit_q;
      if (emit_q) begin
        out_l_q <= left_q;
        out_r_q <= right_q;
      end
    end
  end

  assign OUT_L     = out_l_q;
  assign OUT_R     = out_r_q;
  assign OUT_VALID = valid_q;
  assign OVF       = 1'b0;
`endif

endmodule

// File: tb/tb_k054539_dac_rx.sv
// Self-checking bench for k054539_dac_rx: directed table, corner sequences, random pairs.
module tb_k054539_dac_rx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         nres, dtck, wdck, sdat, clr, out_ready;
  logic [W-1:0] out_l, out_r;
  logic         out_valid, short_err, ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int hs_exp  = 0;

  k054539_dac_rx #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .CLK       (clk),
    .NRES      (nres),
    .DTCK      (dtck),
    .WDCK      (wdck),
    .SDAT      (sdat),
    .CLR       (clr),
    .OUT_L     (out_l),
    .OUT_R     (out_r),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .SHORT_ERR (short_err),
    .OVF       (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid && out_ready) hs_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] l;
    int          ln;
    logic [31:0] r;
    int          rn;
    logic [15:0] el;
    logic [15:0] er;
    logic        es;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Word as the receiver should present it: first W bits sent, MSB-first, zero-padded.
  function automatic logic [15:0] model_word(input logic [31:0] v, input int n);
    longint unsigned x;
    x = longint'(v) & ((64'd1 << n) - 64'd1);
    if (n >= W) return 16'(x >> (n - W));
    return 16'(x << (W - n));
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    dtck = 1'b0;
    sdat = b;
    wait_clk(3);
    dtck = 1'b1;
    wait_clk(3);
  endtask

  task automatic send_word(input logic level, input logic [31:0] v, input int n);
    dtck = 1'b0;
    wdck = level;
    wait_clk(3);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    wait_clk(1);
    clr = 1'b0;
  endtask

  task automatic close_pair();
    dtck = 1'b0;
    wdck = 1'b1;
  endtask

  task automatic wait_pair(input string tag, input logic [15:0] el, input logic [15:0] er,
                           input logic es, input bit chk_lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    repeat (24) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, ".valid"}, 32'(seen), 32'd1);
    if (chk_lat) check({tag, ".latency"}, n, 4);
    check({tag, ".out_l"}, out_l, el);
    check({tag, ".out_r"}, out_r, er);
    check({tag, ".short"}, short_err, es);
    hs_exp++;
    wait_clk(1);
    check({tag, ".pulse"}, out_valid, 1'b0);
`ifndef K054539_DACRX_FIFO_EN
    check({tag, ".hold_l"}, out_l, el);
`endif
  endtask

  task automatic run_pair(input string tag, input vec_t v, input bit chk_lat);
    pulse_clr();
    send_word(1'b1, v.l, v.ln);
    send_word(1'b0, v.r, v.rn);
    close_pair();
    wait_pair(tag, v.el, v.er, v.es, chk_lat);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t rv;
    int   hs_snap;
    logic [31:0] fl[5];
    logic [31:0] fr[5];

    tbl[0] = '{32'h1234,  16, 32'hABCD, 16, 16'h1234, 16'hABCD, 1'b0};
    tbl[1] = '{32'h1234,  16, 32'h0ABC, 12, 16'h1234, 16'hABC0, 1'b1};
    tbl[2] = '{32'h12345, 20, 32'h5A5A, 16, 16'h1234, 16'h5A5A, 1'b0};
    tbl[3] = '{32'h3,      2, 32'hFFFF, 16, 16'hC000, 16'hFFFF, 1'b1};
    tbl[4] = '{32'h0,      0, 32'h8001, 16, 16'h0000, 16'h8001, 1'b1};
    tbl[5] = '{32'hFFFF,  16, 32'h0001, 16, 16'hFFFF, 16'h0001, 1'b0};

    nres = 1'b0; dtck = 1'b0; wdck = 1'b0; sdat = 1'b0; clr = 1'b0; out_ready = 1'b1;
    wait_clk(3);
    check("reset.out_l", out_l, 16'h0);
    check("reset.out_r", out_r, 16'h0);
    check("reset.valid", out_valid, 1'b0);
    check("reset.short", short_err, 1'b0);
    check("reset.ovf", ovf, 1'b0);
    nres = 1'b1;
    wait_clk(2);

    // Garbage while in SYNC, then the rise that enters LEFT: nothing is emitted.
    send_word(1'b0, 32'hFFFF, 16);
    send_word(1'b0, 32'hFFF, 12);
    close_pair();
    wait_clk(12);
    check("sync.no_valid", hs_cnt, 0);
    check("sync.short", short_err, 1'b0);

    for (int i = 0; i < 6; i++) run_pair($sformatf("tbl%0d", i), tbl[i], i == 0);

    pulse_clr();
    check("clr.short", short_err, 1'b0);

    // CLR asserted in the very cycle the short flag is set: set wins.
    send_word(1'b1, 32'h00C3, 16);
    send_word(1'b0, 32'h00A5, 8);
    close_pair();
    wait_clk(2);
    clr = 1'b1;
    wait_clk(1);
    clr = 1'b0;
    wait_pair("clr_vs_set", 16'h00C3, 16'hA500, 1'b1, 1'b0);
    pulse_clr();
    check("clr_vs_set.cleared", short_err, 1'b0);

    // DTCK rise coincident with WDCK rise: bit becomes MSB of the next left word.
    send_word(1'b1, 32'h5555, 16);
    send_word(1'b0, 32'h7FFF, 15);
    dtck = 1'b0;
    sdat = 1'b1;
    wait_clk(3);
    dtck = 1'b1;
    wdck = 1'b1;
    wait_pair("coinc.a", 16'h5555, 16'hFFFE, 1'b1, 1'b1);
    pulse_clr();
    send_word(1'b1, 32'h0, 15);
    send_word(1'b0, 32'h1357, 16);
    close_pair();
    wait_pair("coinc.b", 16'h8000, 16'h1357, 1'b0, 1'b0);

    // Reset in the middle of a right word discards the partial pair.
    send_word(1'b1, 32'h1111, 16);
    send_word(1'b0, 32'h2222, 7);
    nres = 1'b0;
    wait_clk(2);
    check("midrst.out_l", out_l, 16'h0);
    check("midrst.valid", out_valid, 1'b0);
    nres = 1'b1;
    hs_snap = hs_cnt;
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    close_pair();
    wait_clk(12);
    check("midrst.no_valid", hs_cnt, hs_snap);
    run_pair("midrst.pair", '{32'h0F0F, 16, 32'hF0F0, 16, 16'h0F0F, 16'hF0F0, 1'b0}, 1'b1);

    // Random pairs against the arithmetic word model.
    for (int i = 0; i < 8; i++) begin
      rv.l  = $urandom;
      rv.ln = $urandom_range(0, 20);
      rv.r  = $urandom;
      rv.rn = $urandom_range(0, 20);
      rv.el = model_word(rv.l, rv.ln);
      rv.er = model_word(rv.r, rv.rn);
      rv.es = (rv.ln < W) || (rv.rn < W);
      run_pair($sformatf("rnd%0d", i), rv, 1'b0);
    end

`ifdef K054539_DACRX_FIFO_EN
    // Consumer stalled: five pairs into a four-entry FIFO.
    out_ready = 1'b0;
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      fl[i] = 32'(16'hA000 + 16'(i));
      fr[i] = 32'(16'h0500 + 16'(i * 3));
      send_word(1'b1, fl[i], 16);
      send_word(1'b0, fr[i], 16);
      close_pair();
      wait_clk(6);
    end
    wait_clk(6);
    check("fifo.ovf", ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fifo.valid%0d", i), out_valid, 1'b1);
      check($sformatf("fifo.l%0d", i), out_l, fl[i]);
      check($sformatf("fifo.r%0d", i), out_r, fr[i]);
      out_ready = 1'b1;
      hs_exp++;
      wait_clk(1);
      out_ready = 1'b0;
    end
    check("fifo.empty", out_valid, 1'b0);
    pulse_clr();
    check("fifo.ovf_clr", ovf, 1'b0);
    out_ready = 1'b1;
`else
    check("nofifo.ovf", ovf, 1'b0);
`endif

    wait_clk(4);
    check("handshakes", hs_cnt, hs_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
